// File: rtl/fir_mac_scheduler_if.sv
// Handshake/bus bundle for fir_mac_scheduler: start/taps, coefficient write port, results.
interface fir_mac_scheduler_if #(
  parameter int BITS_PER_ELEM = 8,
  parameter int NUM_TAPS      = 9,
  parameter int NUM_FILTERS   = 4,
  parameter int ACC_BITS      = 20
);
  localparam int ADDR_W = $clog2(NUM_FILTERS * NUM_TAPS);
  localparam int IDX_W  = $clog2(NUM_FILTERS);

  logic                              i_start;
  logic [NUM_TAPS*BITS_PER_ELEM-1:0] i_taps;
  logic                              i_coef_wr;
  logic [ADDR_W-1:0]                 i_coef_addr;
  logic [BITS_PER_ELEM-1:0]          i_coef_data;
  logic                              o_busy;
  logic [ACC_BITS-1:0]               o_result;
  logic [IDX_W-1:0]                  o_result_idx;
  logic                              o_result_valid;
  logic                              o_done;
  logic                              o_overrun;
  logic                              o_cfg_err;

  modport master (
    output i_start, i_taps, i_coef_wr, i_coef_addr, i_coef_data,
    input  o_busy, o_result, o_result_idx, o_result_valid, o_done, o_overrun, o_cfg_err
  );

  modport slave (
    input  i_start, i_taps, i_coef_wr, i_coef_addr, i_coef_data,
    output o_busy, o_result, o_result_idx, o_result_valid, o_done, o_overrun, o_cfg_err
  );
endinterface

// File: rtl/fir_mac_scheduler.sv
// Time-shares one signed MAC across NUM_FILTERS coefficient sets for a snapshotted tap
// vector: one tap per cycle, then one emit cycle per filter.
//
// state | meaning
// IDLE  | waiting for i_start; coefficient writes accepted
// MAC   | accumulating tap tap_q of filter filt_q
// EMIT  | publishing filter filt_q's sum, then next filter or back to IDLE
module fir_mac_scheduler #(
  parameter int BITS_PER_ELEM = 8,
  parameter int NUM_TAPS      = 9,
  parameter int NUM_FILTERS   = 4,
  parameter int ACC_BITS      = 20
) (
  input logic                clk,
  input logic                rst,
  fir_mac_scheduler_if.slave bus
);
  localparam int DEPTH  = NUM_FILTERS * NUM_TAPS;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int TAP_W  = $clog2(NUM_TAPS);
  localparam int FILT_W = $clog2(NUM_FILTERS);
  localparam int PROD_W = 2 * BITS_PER_ELEM;
  localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(NUM_TAPS - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(NUM_FILTERS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_EMIT} state_t;

  state_t                          state_q, state_d;
  logic signed [BITS_PER_ELEM-1:0] taps_q [NUM_TAPS];
  logic signed [BITS_PER_ELEM-1:0] taps_d [NUM_TAPS];
  logic signed [BITS_PER_ELEM-1:0] coef_q [DEPTH];
  logic signed [BITS_PER_ELEM-1:0] coef_d [DEPTH];
  logic signed [ACC_BITS-1:0]      acc_q, acc_d;
  logic [TAP_W-1:0]                tap_q, tap_d;
  logic [FILT_W-1:0]               filt_q, filt_d;
  logic [ACC_BITS-1:0]             result_q, result_d;
  logic [FILT_W-1:0]               result_idx_q, result_idx_d;
  logic                            valid_q, valid_d;
  logic                            done_q, done_d;
  logic                            busy_q, busy_d;
  logic                            overrun_q, overrun_d;
  logic                            cfg_err_q, cfg_err_d;

  logic [ADDR_W-1:0]               coef_idx;
  logic signed [PROD_W-1:0]        prod;
  logic                            addr_ok;

  always_comb begin
    coef_idx = ADDR_W'(int'(filt_q) * NUM_TAPS + int'(tap_q));
    prod     = taps_q[tap_q] * coef_q[coef_idx];
    addr_ok  = {1'b0, bus.i_coef_addr} < (ADDR_W + 1)'(DEPTH);
  end

  always_comb begin
    state_d      = state_q;
    taps_d       = taps_q;
    coef_d       = coef_q;
    acc_d        = acc_q;
    tap_d        = tap_q;
    filt_d       = filt_q;
    result_d     = result_q;
    result_idx_d = result_idx_q;
    valid_d      = 1'b0;
    done_d       = 1'b0;
    busy_d       = busy_q;
    overrun_d    = 1'b0;
    cfg_err_d    = 1'b0;

    // Writes land only in IDLE, so a run always sees one consistent coefficient set.
    if (bus.i_coef_wr) begin
      if (state_q == ST_IDLE && addr_ok) coef_d[bus.i_coef_addr] = bus.i_coef_data;
      else                               cfg_err_d = 1'b1;
    end
    if (bus.i_start && state_q != ST_IDLE) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          for (int k = 0; k < NUM_TAPS; k++)
            taps_d[k] = bus.i_taps[k*BITS_PER_ELEM +: BITS_PER_ELEM];
          acc_d   = '0;
          tap_d   = '0;
          filt_d  = '0;
          busy_d  = 1'b1;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + {{(ACC_BITS-PROD_W){prod[PROD_W-1]}}, prod};
        if (tap_q == TAP_LAST) state_d = ST_EMIT;
        else                   tap_d   = tap_q + TAP_W'(1);
      end
      ST_EMIT: begin
        result_d     = acc_q;
        result_idx_d = filt_q;
        valid_d      = 1'b1;
        acc_d        = '0;
        tap_d        = '0;
        if (filt_q == FILT_LAST) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          filt_d  = filt_q + FILT_W'(1);
          state_d = ST_MAC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      taps_q       <= '{default: '0};
      coef_q       <= '{default: '0};
      acc_q        <= '0;
      tap_q        <= '0;
      filt_q       <= '0;
      result_q     <= '0;
      result_idx_q <= '0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      taps_q       <= taps_d;
      coef_q       <= coef_d;
      acc_q        <= acc_d;
      tap_q        <= tap_d;
      filt_q       <= filt_d;
      result_q     <= result_d;
      result_idx_q <= result_idx_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign bus.o_busy         = busy_q;
  assign bus.o_result       = result_q;
  assign bus.o_result_idx   = result_idx_q;
  assign bus.o_result_valid = valid_q;
  assign bus.o_done         = done_q;
  assign bus.o_overrun      = overrun_q;
  assign bus.o_cfg_err      = cfg_err_q;
endmodule
